// File: rtl/hash_in_buffer_pkg.sv
// Shared definitions for the absorb-side staging buffer of the sliced Keccak core.
package hash_in_buffer_pkg;

  localparam int         RATE_LANES   = 21;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // Bit offset of lane k, byte b inside the ascending-indexed rate block.
  function automatic int lane_byte(input int k, input int b);
    return 64 * k + 8 * b;
  endfunction

endpackage

// File: rtl/hash_slice_mux.sv
// Picks one byte from every lane of the rate block, selected by the core's sub-round counter.
module hash_slice_mux
  import hash_in_buffer_pkg::*;
#(
  parameter int LANES = RATE_LANES
) (
  input  logic [0:LANES*64-1] blk,
  input  logic [2:0]          slice_sel,
  output logic [0:LANES*8-1]  ci_in
);

  // The core counts sub-rounds down from 7, so slice 7 carries byte 0 of each lane.
  always_comb begin
    ci_in = '0;
    for (int k = 0; k < LANES; k++) begin
      ci_in[8*k +: 8] = blk[lane_byte(k, 7 - int'(slice_sel)) +: 8];
    end
  end

endmodule

// File: rtl/hash_in_buffer.sv
// Absorb-side staging buffer: packs 64-bit message words into one SHAKE128 rate block,
// applies SHAKE padding and hands the block to the core one byte-slice per lane at a time.
module hash_in_buffer
  import hash_in_buffer_pkg::*;
#(
  parameter int         RATE_LANES = hash_in_buffer_pkg::RATE_LANES,
  parameter logic [7:0] DOMAIN     = DOMAIN_SHAKE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:63]               din_64,
  input  logic                      din_valid,
  input  logic                      din_last,
  input  logic [3:0]                din_last_bytes,
  output logic                      din_ready,
  output logic                      blk_valid,
  output logic                      blk_last,
  input  logic [2:0]                slice_sel,
  output logic [0:RATE_LANES*8-1]   ci_in,
  input  logic                      blk_done,
  output logic [1:0]                state_dbg
);

  // Handshake: a word moves when din_valid & din_ready are both high at posedge clk;
  // the source must hold din_64/din_last/din_last_bytes stable until then.
  localparam int         BLK_W     = RATE_LANES * 64;
  localparam int         LAST_BYTE = lane_byte(RATE_LANES - 1, 7);
  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  state_t               state, next_state;
  logic [0:BLK_W-1]     blk_buf;
  logic [0:BLK_W-1]     pad_buf;
  logic [0:BLK_W-1]     pad_only;
  logic [4:0]           word_cnt;
  logic [7:0]           pad_pos;
  logic                 pad_pend;
  logic                 gap;
  logic [3:0]           n_eff;
  logic                 exact_fit;
  logic                 done_take;
  logic [0:63]          word_masked;
  logic [0:RATE_LANES*8-1] slice_raw;

  assign n_eff     = (din_last_bytes > 4'd8) ? 4'd8 : din_last_bytes;
  assign exact_fit = (n_eff == 4'd8) && (word_cnt == LAST_LANE);
  assign done_take = (state == S_FULL) && blk_done && !gap;
  assign state_dbg = state;

  always_comb begin
    word_masked = '0;
    for (int j = 0; j < 8; j++) begin
      if (!din_last || (4'(j) < n_eff)) word_masked[8*j +: 8] = din_64[8*j +: 8];
    end
  end

  // Bytes past the message are already zero: the buffer is cleared per block and the
  // tail of the last word is masked, so padding only needs the two marker bytes.
  always_comb begin
    pad_buf = blk_buf;
    pad_buf[8*int'(pad_pos) +: 8] = DOMAIN;
    pad_buf[LAST_BYTE +: 8] = pad_buf[LAST_BYTE +: 8] | PAD_END;
  end

  always_comb begin
    pad_only = '0;
    pad_only[0 +: 8] = DOMAIN;
    pad_only[LAST_BYTE +: 8] = pad_only[LAST_BYTE +: 8] | PAD_END;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    din_ready  = 1'b0;
    blk_valid  = 1'b0;
    case (state)
      S_FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          if (din_last)                   next_state = exact_fit ? S_FULL : S_PAD;
          else if (word_cnt == LAST_LANE) next_state = S_FULL;
        end
      end
      S_PAD:  next_state = S_FULL;
      S_FULL: begin
        blk_valid = !gap;
        if (done_take && !pad_pend) next_state = S_FILL;
      end
      default: next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_buf  <= '0;
      word_cnt <= '0;
      pad_pos  <= '0;
      pad_pend <= 1'b0;
      blk_last <= 1'b0;
      gap      <= 1'b0;
    end else begin
      gap <= 1'b0;
      if (state == S_FILL && din_valid) begin
        blk_buf[lane_byte(int'(word_cnt), 0) +: 64] <= word_masked;
        if (din_last) begin
          pad_pos  <= {word_cnt, 3'b000} + {4'b0000, n_eff};
          pad_pend <= exact_fit;
          blk_last <= 1'b0;
        end else begin
          word_cnt <= word_cnt + 5'd1;
        end
      end
      if (state == S_PAD) begin
        blk_buf  <= pad_buf;
        blk_last <= 1'b1;
      end
      // An exact-fit message still owes a pad-only block; gap drops blk_valid for one cycle.
      if (done_take) begin
        if (pad_pend) begin
          blk_buf  <= pad_only;
          pad_pend <= 1'b0;
          blk_last <= 1'b1;
          gap      <= 1'b1;
        end else begin
          blk_buf  <= '0;
          word_cnt <= '0;
          blk_last <= 1'b0;
        end
      end
    end
  end

  hash_slice_mux #(.LANES(RATE_LANES)) u_slice_mux (
    .blk       (blk_buf),
    .slice_sel (slice_sel),
    .ci_in     (slice_raw)
  );

  assign ci_in = blk_valid ? slice_raw : '0;

endmodule

// File: tb/tb_hash_in_buffer.sv
// Scenario bench for hash_in_buffer: a byte-stream SHAKE padding model fills the expected queue.
module tb_hash_in_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:63]  din_64;
  logic         din_valid;
  logic         din_last;
  logic [3:0]   din_last_bytes;
  logic         din_ready;
  logic         blk_valid;
  logic         blk_last;
  logic [2:0]   slice_sel;
  logic [0:167] ci_in;
  logic         blk_done;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [167:0] exp_q[$];
  logic         exp_last_q[$];
  logic [7:0]   msg_q[$];

  logic [0:167] obs_s [8];
  logic         obs_last;
  logic         drain_ok;
  logic [0:167] exp_sl;
  logic         exp_l;

  always #5 clk = ~clk;

  hash_in_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .din_64         (din_64),
    .din_valid      (din_valid),
    .din_last       (din_last),
    .din_last_bytes (din_last_bytes),
    .din_ready      (din_ready),
    .blk_valid      (blk_valid),
    .blk_last       (blk_last),
    .slice_sel      (slice_sel),
    .ci_in          (ci_in),
    .blk_done       (blk_done),
    .state_dbg      (state_dbg)
  );

  // Reference: message bytes, then 0x1F, zeros, and 0x80 OR'd into the final rate byte.
  task automatic model_push();
    int len;
    int nblk;
    int idx;
    logic [7:0] b [168];
    logic [0:167] sl;
    len  = msg_q.size();
    nblk = len / 168 + 1;
    for (int blk = 0; blk < nblk; blk++) begin
      for (int i = 0; i < 168; i++) begin
        idx  = blk * 168 + i;
        b[i] = (idx < len) ? msg_q[idx] : 8'h00;
        if (idx == len) b[i] = 8'h1F;
        if (blk == nblk - 1 && i == 167) b[i] = b[i] | 8'h80;
      end
      for (int s = 0; s < 8; s++) begin
        for (int k = 0; k < 21; k++) sl[8*k +: 8] = b[8*k + s];
        exp_q.push_back(sl);
      end
      exp_last_q.push_back(blk == nblk - 1);
    end
    msg_q.delete();
  endtask

  task automatic send_word(input logic [0:63] w, input logic last, input logic [3:0] n);
    logic acc;
    int cyc;
    for (int j = 0; j < 8; j++) if (!last || j < int'(n)) msg_q.push_back(w[8*j +: 8]);
    din_64 = w; din_last = last; din_last_bytes = n; din_valid = 1'b1;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 100) begin
      acc = din_ready;
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0; din_last = 1'b0; din_last_bytes = 4'd0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_word_timeout din_ready stayed %b, required 1", din_ready);
    end
  endtask

  // Acts as the core: waits for a block, reads slices 7..0 one per cycle, then pulses blk_done.
  task automatic drain_block();
    int cyc;
    cyc = 0;
    while (!blk_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    drain_ok = blk_valid;
    obs_last = blk_last;
    for (int s = 0; s < 8; s++) begin
      slice_sel = 3'(7 - s);
      #2;
      obs_s[s] = ci_in;
      @(posedge clk); #1;
    end
    blk_done = 1'b1;
    @(posedge clk); #1;
    blk_done  = 1'b0;
    slice_sel = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0; din_last = 1'b0; din_last_bytes = 4'd0;
    din_64 = '0; slice_sel = 3'd0; blk_done = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b required 1", din_ready); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got %b required 0", blk_valid); end
    checks++; if (blk_last !== 1'b0) begin errors++; $display("FAIL reset_blk_last got %b required 0", blk_last); end
    checks++; if (ci_in !== '0) begin errors++; $display("FAIL reset_ci_in got %h required 0", ci_in); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d required 0", state_dbg); end
  endtask

  task automatic test_single_word(input string tag);
    send_word(64'h0011223344556677, 1'b1, 4'd8);
    model_push();
    slice_sel = 3'd0; #1;
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL %s_pad_cycle_valid got %b required 0", tag, blk_valid); end
    checks++; if (ci_in !== '0) begin errors++; $display("FAIL %s_pad_cycle_ci got %h required 0", tag, ci_in); end
    @(posedge clk); #1;
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL %s_blk_valid got %b required 1", tag, blk_valid); end
    checks++; if (blk_last !== 1'b1) begin errors++; $display("FAIL %s_blk_last_now got %b required 1", tag, blk_last); end
    slice_sel = 3'd7; #1;
    checks++; if (ci_in[0:7] !== 8'h00) begin errors++; $display("FAIL %s_s7_lane0 got %h required 00", tag, ci_in[0:7]); end
    checks++; if (ci_in[8:15] !== 8'h1F) begin errors++; $display("FAIL %s_s7_lane1 got %h required 1f", tag, ci_in[8:15]); end
    slice_sel = 3'd0; #1;
    checks++; if (ci_in[0:7] !== 8'h77) begin errors++; $display("FAIL %s_s0_lane0 got %h required 77", tag, ci_in[0:7]); end
    checks++; if (ci_in[160:167] !== 8'h80) begin errors++; $display("FAIL %s_s0_lane20 got %h required 80", tag, ci_in[160:167]); end
    drain_block();
    checks++; if (!drain_ok) begin errors++; $display("FAIL %s_drain blk_valid got 0 required 1", tag); end
    for (int s = 0; s < 8; s++) begin
      exp_sl = exp_q.pop_front(); checks++;
      if (obs_s[s] !== exp_sl) begin errors++; $display("FAIL %s_slice%0d got %h required %h", tag, s, obs_s[s], exp_sl); end
    end
    exp_l = exp_last_q.pop_front(); checks++;
    if (obs_last !== exp_l) begin errors++; $display("FAIL %s_blk_last got %b required %b", tag, obs_last, exp_l); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b required 1", tag, din_ready); end
  endtask

  task automatic test_empty_message();
    send_word(64'hDEADBEEFCAFEF00D, 1'b1, 4'd0);
    model_push();
    drain_block();
    checks++; if (!drain_ok) begin errors++; $display("FAIL empty_drain blk_valid got 0 required 1"); end
    for (int s = 0; s < 8; s++) begin
      exp_sl = exp_q.pop_front(); checks++;
      if (obs_s[s] !== exp_sl) begin errors++; $display("FAIL empty_slice%0d got %h required %h", s, obs_s[s], exp_sl); end
    end
    exp_l = exp_last_q.pop_front(); checks++;
    if (obs_last !== exp_l) begin errors++; $display("FAIL empty_blk_last got %b required %b", obs_last, exp_l); end
  endtask

  task automatic test_exact_fit();
    for (int w = 0; w < 21; w++) send_word({$urandom, $urandom}, w == 20, 4'd8);
    model_push();
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL exact_first_valid got %b required 1", blk_valid); end
    checks++; if (blk_last !== 1'b0) begin errors++; $display("FAIL exact_first_last got %b required 0", blk_last); end
    for (int b = 0; b < 2; b++) begin
      drain_block();
      checks++; if (!drain_ok) begin errors++; $display("FAIL exact_drain%0d blk_valid got 0 required 1", b); end
      for (int s = 0; s < 8; s++) begin
        exp_sl = exp_q.pop_front(); checks++;
        if (obs_s[s] !== exp_sl) begin errors++; $display("FAIL exact_b%0d_slice%0d got %h required %h", b, s, obs_s[s], exp_sl); end
      end
      exp_l = exp_last_q.pop_front(); checks++;
      if (obs_last !== exp_l) begin errors++; $display("FAIL exact_b%0d_last got %b required %b", b, obs_last, exp_l); end
      if (b == 0) begin
        slice_sel = 3'd7; #1;
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL exact_gap_valid got %b required 0", blk_valid); end
        checks++; if (ci_in !== '0) begin errors++; $display("FAIL exact_gap_ci got %h required 0", ci_in); end
        @(posedge clk); #1;
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL exact_pad_valid got %b required 1", blk_valid); end
      end
    end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL exact_ready_after got %b required 1", din_ready); end
  endtask

  task automatic test_last_byte_shared();
    for (int w = 0; w < 21; w++) send_word({$urandom, $urandom}, w == 20, 4'd7);
    model_push();
    drain_block();
    checks++; if (!drain_ok) begin errors++; $display("FAIL n7_drain blk_valid got 0 required 1"); end
    checks++; if (obs_s[7][160:167] !== 8'h9F) begin errors++; $display("FAIL n7_lane20_byte7 got %h required 9f", obs_s[7][160:167]); end
    for (int s = 0; s < 8; s++) begin
      exp_sl = exp_q.pop_front(); checks++;
      if (obs_s[s] !== exp_sl) begin errors++; $display("FAIL n7_slice%0d got %h required %h", s, obs_s[s], exp_sl); end
    end
    exp_l = exp_last_q.pop_front(); checks++;
    if (obs_last !== exp_l) begin errors++; $display("FAIL n7_blk_last got %b required %b", obs_last, exp_l); end
  endtask

  task automatic test_backpressure();
    logic [0:63] w_pend;
    logic [3:0]  n_pend;
    for (int w = 0; w < 21; w++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    w_pend = {$urandom, $urandom};
    n_pend = 4'($urandom_range(1, 6));
    din_64 = w_pend; din_last = 1'b1; din_last_bytes = n_pend; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got %b required 0", i, din_ready); end
      checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL bp_state_c%0d got %0d required 2", i, state_dbg); end
      @(posedge clk); #1;
    end
    fork
      send_word(w_pend, 1'b1, n_pend);
      drain_block();
    join
    model_push();
    for (int b = 0; b < 2; b++) begin
      if (b == 1) drain_block();
      checks++; if (!drain_ok) begin errors++; $display("FAIL bp_drain%0d blk_valid got 0 required 1", b); end
      for (int s = 0; s < 8; s++) begin
        exp_sl = exp_q.pop_front(); checks++;
        if (obs_s[s] !== exp_sl) begin errors++; $display("FAIL bp_b%0d_slice%0d got %h required %h", b, s, obs_s[s], exp_sl); end
      end
      exp_l = exp_last_q.pop_front(); checks++;
      if (obs_last !== exp_l) begin errors++; $display("FAIL bp_b%0d_last got %b required %b", b, obs_last, exp_l); end
    end
  endtask

  task automatic test_reset_mid_block();
    for (int w = 0; w < 10; w++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    msg_q.delete();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b required 1", din_ready); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b required 0", blk_valid); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d required 0", state_dbg); end
    for (int s = 0; s < 8; s++) begin
      slice_sel = 3'(s); #1;
      checks++; if (ci_in !== '0) begin errors++; $display("FAIL rstmid_ci_sel%0d got %h required 0", s, ci_in); end
    end
    slice_sel = 3'd0;
    @(posedge clk); #1;
    test_single_word("t6");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word("t1");
    test_empty_message();
    test_exact_fit();
    test_last_byte_shared();
    test_backpressure();
    test_reset_mid_block();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
